keyboard_irq_fifo: RTL and testbench

//  Parametrised keyboard interrupt source: polls the key strobe on a programmable period, debounces it,
//  and queues the scan value captured at each press in a small FIFO.

---
 rtl/keyboard_irq_fifo.sv | 192 +++++++++++++++++++
 tb/tb_keyboard_irq_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_irq_fifo.sv
// Polled, debounced keyboard interrupt source that queues scan values in a small FIFO.
// Optional auto-repeat while a key is held: define KEYBOARD_REPEAT_EN.
module keyboard_irq_fifo #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned POLL_PERIOD  = 1000000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [3:0]  IRQ_INDEX    = 4'd1,
  parameter int unsigned REPEAT_POLLS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          keyDown,
  input  logic [DATA_W-1:0]             inputValue,
  input  logic                          intAck,
  output logic                          interruptSignal,
  output logic [3:0]                    interruptIndex,
  output logic [DATA_W-1:0]             data,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow
);

  localparam int unsigned TMR_W = $clog2(POLL_PERIOD);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

  logic [TMR_W-1:0]  r_timer;
  logic              w_tick;
  state_t            r_state, w_state_nxt;
  logic [DB_W-1:0]   r_db, w_db_nxt, w_db_inc;
  logic              w_press_push;
  logic              w_push;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd, w_rd_inc;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              w_full, w_empty, w_pop, w_wr_en;
  logic [DATA_W-1:0] r_data, w_head_nxt;
  logic              r_irq_n, w_irq_n_nxt;
  logic [3:0]        r_idx;
  logic              r_ovf;

  // Poll timer: one tick every POLL_PERIOD cycles
  assign w_tick = (r_timer == TMR_W'(POLL_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_timer <= '0;
    else if (w_tick) r_timer <= '0;
    else             r_timer <= r_timer + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RELEASED;
      r_db    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_db    <= w_db_nxt;
    end
  end

  assign w_db_inc = r_db + DB_W'(1);

  // Debounce: DEBOUNCE consecutive equal samples flip the key state
  always_comb begin
    w_state_nxt  = r_state;
    w_db_nxt     = r_db;
    w_press_push = 1'b0;
    if (w_tick) begin
      case (r_state)
        RELEASED: begin
          if (!keyDown) begin
            if (w_db_inc >= DB_W'(DEBOUNCE)) begin
              w_state_nxt  = PRESSED;
              w_db_nxt     = '0;
              w_press_push = 1'b1;
            end else begin
              w_db_nxt = w_db_inc;
            end
          end else begin
            w_db_nxt = '0;
          end
        end
        PRESSED: begin
          if (keyDown) begin
            if (w_db_inc >= DB_W'(DEBOUNCE)) begin
              w_state_nxt = RELEASED;
              w_db_nxt    = '0;
            end else begin
              w_db_nxt = w_db_inc;
            end
          end else begin
            w_db_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = RELEASED;
          w_db_nxt    = '0;
        end
      endcase
    end
  end

`ifdef KEYBOARD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_POLLS + 1);

  logic [REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc;
  logic             w_rep_push;

  assign w_rep_inc = r_rep + REP_W'(1);

  // Held key: a new event every REPEAT_POLLS pressed ticks
  always_comb begin
    w_rep_nxt  = r_rep;
    w_rep_push = 1'b0;
    if (w_tick) begin
      if (r_state == PRESSED && !keyDown) begin
        if (w_rep_inc >= REP_W'(REPEAT_POLLS)) begin
          w_rep_nxt  = '0;
          w_rep_push = 1'b1;
        end else begin
          w_rep_nxt = w_rep_inc;
        end
      end else begin
        w_rep_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rep <= '0;
    else      r_rep <= w_rep_nxt;
  end

  assign w_push = w_press_push | w_rep_push;
`else
  assign w_push = w_press_push;
`endif

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = intAck && !r_irq_n && !w_empty;
  assign w_wr_en     = w_push && (!w_full || w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_wr_en) - CNT_W'(w_pop);
  assign w_rd_inc    = r_rd + AW'(1);
  assign w_irq_n_nxt = !(!w_empty && !w_pop);

  // Head value as it will look after this edge, so data is a plain register
  always_comb begin
    w_head_nxt = r_mem[r_rd];
    if (w_count_nxt == '0)
      w_head_nxt = '0;
    else if (w_empty || (w_pop && r_count == CNT_W'(1)))
      w_head_nxt = inputValue;
    else if (w_pop)
      w_head_nxt = r_mem[w_rd_inc];
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= inputValue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_irq_n <= 1'b1;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_pop)   r_rd <= w_rd_inc;
      r_count <= w_count_nxt;
      r_data  <= w_head_nxt;
      r_irq_n <= w_irq_n_nxt;
      r_idx   <= w_irq_n_nxt ? 4'd0 : IRQ_INDEX;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign interruptSignal = r_irq_n;
  assign interruptIndex  = r_idx;
  assign data            = r_data;
  assign pending         = r_count;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_keyboard_irq_fifo.sv
// Directed bench for keyboard_irq_fifo with a 4-cycle poll period, 2-sample debounce, 2-deep FIFO.
module tb_keyboard_irq_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyDown;
  logic [15:0] inputValue;
  logic        intAck;
  logic        interruptSignal;
  logic [3:0]  interruptIndex;
  logic [15:0] data;
  logic [1:0]  pending;
  logic        overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  keyboard_irq_fifo #(
    .DATA_W(16), .POLL_PERIOD(4), .DEBOUNCE(2), .FIFO_DEPTH(2),
    .IRQ_INDEX(4'd1), .REPEAT_POLLS(3)
  ) dut (
    .clk(clk), .rst(rst), .keyDown(keyDown), .inputValue(inputValue), .intAck(intAck),
    .interruptSignal(interruptSignal), .interruptIndex(interruptIndex),
    .data(data), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Poll ticks land on edges where cyc becomes a multiple of 4
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    do step(); while (cyc % 4 != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; keyDown = 1'b1; intAck = 1'b0; inputValue = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic press(input logic [15:0] val);
    keyDown = 1'b0; inputValue = val;
    tick(); tick();
    keyDown = 1'b1; inputValue = 16'hFFFF;
    tick(); tick();
  endtask

  task automatic ack();
    intAck = 1'b1;
    step();
    intAck = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL rst_irq: got %b want 1", interruptSignal); end
    n_vec++; if (interruptIndex !== 4'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", interruptIndex); end
    n_vec++; if (data !== 16'h0) begin n_err++; $display("FAIL rst_data: got %h want 0000", data); end
    n_vec++; if (pending !== 2'd0) begin n_err++; $display("FAIL rst_pending: got %0d want 0", pending); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_press();
    keyDown = 1'b0; inputValue = 16'h0040;
    tick();
    n_vec++; if (pending !== 2'd0) begin n_err++; $display("FAIL press_early: got %0d want 0", pending); end
    inputValue = 16'h0041;
    tick();
    n_vec++; if (data !== 16'h0041) begin n_err++; $display("FAIL press_data: got %h want 0041", data); end
    n_vec++; if (pending !== 2'd1) begin n_err++; $display("FAIL press_pending: got %0d want 1", pending); end
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL press_irq_lat: got %b want 1", interruptSignal); end
    step();
    n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL press_irq: got %b want 0", interruptSignal); end
    n_vec++; if (interruptIndex !== 4'd1) begin n_err++; $display("FAIL press_idx: got %0d want 1", interruptIndex); end
    tick();
    n_vec++; if (pending !== 2'd1) begin n_err++; $display("FAIL press_single: got %0d want 1", pending); end
    keyDown = 1'b1;
    tick(); tick();
    ack();
    n_vec++; if (pending !== 2'd0) begin n_err++; $display("FAIL pop_pending: got %0d want 0", pending); end
    n_vec++; if (data !== 16'h0) begin n_err++; $display("FAIL pop_data: got %h want 0000", data); end
    n_vec++; if (interruptSignal !== 1'b1 || interruptIndex !== 4'd0) begin n_err++; $display("FAIL pop_irq: got %b/%0d want 1/0", interruptSignal, interruptIndex); end
    step();
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL empty_irq: got %b want 1", interruptSignal); end
  endtask

  task automatic test_glitch();
    keyDown = 1'b0; inputValue = 16'h0099;
    tick();
    keyDown = 1'b1;
    tick(); tick();
    n_vec++; if (pending !== 2'd0) begin n_err++; $display("FAIL glitch_pending: got %0d want 0", pending); end
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL glitch_irq: got %b want 1", interruptSignal); end
  endtask

  task automatic test_overflow();
    press(16'h0001); press(16'h0002); press(16'h0003);
    n_vec++; if (pending !== 2'd2) begin n_err++; $display("FAIL ovf_pending: got %0d want 2", pending); end
    n_vec++; if (data !== 16'h0001) begin n_err++; $display("FAIL ovf_data: got %h want 0001", data); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_vec++; if (interruptSignal !== 1'b0 || interruptIndex !== 4'd1) begin n_err++; $display("FAIL ovf_irq: got %b/%0d want 0/1", interruptSignal, interruptIndex); end
    ack();
    n_vec++; if (data !== 16'h0002) begin n_err++; $display("FAIL ovf_pop_data: got %h want 0002", data); end
    n_vec++; if (pending !== 2'd1) begin n_err++; $display("FAIL ovf_pop_pending: got %0d want 1", pending); end
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL ovf_pop_irq_hi: got %b want 1", interruptSignal); end
    step();
    n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL ovf_pop_irq_lo: got %b want 0", interruptSignal); end
  endtask

  task automatic test_async_reset();
    press(16'h0007);
    keyDown = 1'b0; inputValue = 16'h0008;
    tick();
    #2 rst = 1'b0;
    #1;
    n_vec++; if (interruptSignal !== 1'b1 || interruptIndex !== 4'd0) begin n_err++; $display("FAIL arst_irq: got %b/%0d want 1/0", interruptSignal, interruptIndex); end
    n_vec++; if (data !== 16'h0 || pending !== 2'd0) begin n_err++; $display("FAIL arst_fifo: got %h/%0d want 0000/0", data, pending); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL arst_ovf: got %b want 0", overflow); end
    do_reset();
    keyDown = 1'b0; inputValue = 16'h0008;
    tick();
    n_vec++; if (pending !== 2'd0) begin n_err++; $display("FAIL arst_debounce: got %0d want 0", pending); end
    tick();
    n_vec++; if (pending !== 2'd1 || data !== 16'h0008) begin n_err++; $display("FAIL arst_press: got %0d/%h want 1/0008", pending, data); end
    keyDown = 1'b1;
    tick(); tick();
    ack();
  endtask

  task automatic test_ack_on_full_push();
    press(16'h000A); press(16'h000B);
    n_vec++; if (pending !== 2'd2) begin n_err++; $display("FAIL full_pending: got %0d want 2", pending); end
    keyDown = 1'b0; inputValue = 16'h000C;
    tick();
    while (cyc % 4 != 3) step();
    ack();
    n_vec++; if (pending !== 2'd2) begin n_err++; $display("FAIL pushpop_pending: got %0d want 2", pending); end
    n_vec++; if (data !== 16'h000B) begin n_err++; $display("FAIL pushpop_data: got %h want 000b", data); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pushpop_ovf: got %b want 0", overflow); end
    n_vec++; if (interruptSignal !== 1'b1) begin n_err++; $display("FAIL pushpop_irq: got %b want 1", interruptSignal); end
    step();
    n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL pushpop_irq_lo: got %b want 0", interruptSignal); end
    keyDown = 1'b1;
    tick(); tick();
    ack();
    n_vec++; if (data !== 16'h000C) begin n_err++; $display("FAIL drain_data: got %h want 000c", data); end
    step();
    ack();
    n_vec++; if (pending !== 2'd0 || data !== 16'h0) begin n_err++; $display("FAIL drain_empty: got %0d/%h want 0/0000", pending, data); end
  endtask

  task automatic test_ack_ignored();
    ack();
    n_vec++; if (pending !== 2'd0 || data !== 16'h0 || interruptSignal !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ack_empty: got %0d/%h/%b/%b want 0/0000/1/0", pending, data, interruptSignal, overflow);
    end
    keyDown = 1'b0; inputValue = 16'h0077;
    tick(); tick();
    ack();
    n_vec++; if (pending !== 2'd1 || data !== 16'h0077) begin n_err++; $display("FAIL ack_irq_high: got %0d/%h want 1/0077", pending, data); end
    n_vec++; if (interruptSignal !== 1'b0) begin n_err++; $display("FAIL ack_irq_high_irq: got %b want 0", interruptSignal); end
    keyDown = 1'b1;
    tick(); tick();
    ack();
  endtask

  task automatic test_repeat();
    logic exp_push;
    int unsigned pushes = 0;
    do_reset();
    keyDown = 1'b0; inputValue = 16'h0055;
    for (int t = 1; t <= 10; t++) begin
      tick();
`ifdef KEYBOARD_REPEAT_EN
      exp_push = (t == 2 || t == 5 || t == 8);
`else
      exp_push = (t == 2);
`endif
      n_vec++;
      if (pending !== {1'b0, exp_push} || (exp_push && data !== 16'h0055)) begin
        n_err++; $display("FAIL repeat_tick%0d: got %0d/%h want %0d", t, pending, data, exp_push);
      end
      if (pending == 2'd1) pushes++;
      step();
      ack();
    end
    n_vec++;
`ifdef KEYBOARD_REPEAT_EN
    if (pushes != 3) begin n_err++; $display("FAIL repeat_total: got %0d want 3", pushes); end
`else
    if (pushes != 1) begin n_err++; $display("FAIL repeat_total: got %0d want 1", pushes); end
`endif
    keyDown = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; keyDown = 1'b1; intAck = 1'b0; inputValue = 16'h0;
    test_reset();
    test_press();
    test_glitch();
    test_overflow();
    test_async_reset();
    test_ack_on_full_push();
    test_ack_ignored();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
